// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: MEM->WB bus record and register-file geometry
package wb_stage_pkg;
  localparam int RF_DEPTH = 32;
  typedef struct packed {
    logic [4:0]  dest;
    logic        we;
    logic [31:0] result;
    logic [31:0] daddr;
    logic [31:0] pc;
  } mem2wb_t;
endpackage

// File: rtl/common.vh
// common.vh: shared MEM->WB bus layout and register-file widths
`ifndef COMMON_VH
`define COMMON_VH
`define MEM2WBBusSize 102
`define WB_DEST_LSB   97
`define WB_WE_BIT     96
`define WB_RESULT_LSB 64
`define WB_DADDR_LSB  32
`define WB_PC_LSB     0
`define RegW          32
`define RegAddrBusW   5
`endif

// File: rtl/wb_stage_regfile.sv
// wb_stage_regfile: 32x32 register file, r0 hardwired to zero, optional write-to-read bypass
module wb_stage_regfile import wb_stage_pkg::*; #(
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] rf [RF_DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    else if (we && waddr != '0) rf[waddr] <= wdata;
  assign rdata1 = raddr1 == '0 ? '0 : (RF_BYPASS && we && raddr1 == waddr) ? wdata : rf[raddr1];
  assign rdata2 = raddr2 == '0 ? '0 : (RF_BYPASS && we && raddr2 == waddr) ? wdata : rf[raddr2];
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage owning the register file, retire counter and debug trace
`include "common.vh"
module wb_stage import wb_stage_pkg::*; #(
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [`MEM2WBBusSize-1:0] mem2wb_bus_i,
  input  logic                      ctl_mem_over_i,
  input  logic                      ctl_wb_stall_i,
  output logic                      ctl_wb_allowin_o,
  output logic                      ctl_wb_valid_o,
  output logic [`RegAddrBusW-1:0]   ctl_wb_dest_o,
  output logic [`RegW-1:0]          ctl_wb_pc_o,
  input  logic [4:0]                rf_raddr1_i,
  input  logic [4:0]                rf_raddr2_i,
  output logic [31:0]               rf_rdata1_o,
  output logic [31:0]               rf_rdata2_o,
  output logic [31:0]               debug_wb_pc_o,
  output logic [3:0]                debug_wb_rf_wen_o,
  output logic [4:0]                debug_wb_rf_wnum_o,
  output logic [31:0]               debug_wb_rf_wdata_o,
  output logic [31:0]               debug_wb_daddr_o,
  output logic [CNT_W-1:0]          retire_cnt_o
);
  mem2wb_t          bus;
  logic             wb_valid;
  logic [CNT_W-1:0] cnt;
  logic             wb_over, allowin, rf_we;
  assign wb_over = wb_valid && !ctl_wb_stall_i;
  assign allowin = !wb_valid || wb_over;
  assign rf_we   = wb_over && bus.we && bus.dest != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_valid <= 1'b0;
      bus      <= '0;
      cnt      <= '0;
    end else begin
      if (allowin) wb_valid <= ctl_mem_over_i;
      if (allowin && ctl_mem_over_i) bus <= mem2wb_t'(mem2wb_bus_i);
      if (wb_over) cnt <= cnt + CNT_W'(1);
    end
  wb_stage_regfile #(.RF_BYPASS(RF_BYPASS)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (bus.dest),
    .wdata  (bus.result),
    .raddr1 (rf_raddr1_i),
    .raddr2 (rf_raddr2_i),
    .rdata1 (rf_rdata1_o),
    .rdata2 (rf_rdata2_o)
  );
  assign ctl_wb_allowin_o    = allowin;
  assign ctl_wb_valid_o      = wb_valid;
  assign ctl_wb_dest_o       = bus.dest & {5{wb_valid && bus.we}};
  assign ctl_wb_pc_o         = bus.pc;
  assign debug_wb_pc_o       = wb_valid ? bus.pc : '0;
  assign debug_wb_rf_wen_o   = {4{rf_we}};
  assign debug_wb_rf_wnum_o  = wb_valid ? bus.dest : '0;
  assign debug_wb_rf_wdata_o = wb_valid ? bus.result : '0;
  assign debug_wb_daddr_o    = wb_valid ? bus.daddr : '0;
  assign retire_cnt_o        = cnt;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a behavioural pipeline model
module tb_wb_stage;
  localparam int CNT_W = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [101:0] bus = '0;
  logic         mem_over = 1'b0;
  logic         stall = 1'b0;
  logic [4:0]   raddr1 = '0, raddr2 = '0;
  logic         allowin, valid;
  logic [4:0]   dest, wnum;
  logic [31:0]  pc, rdata1, rdata2, dpc, wdata, daddr;
  logic [3:0]   wen;
  logic [CNT_W-1:0] cnt;
  int checks = 0;
  int failures = 0;
  // model: instruction currently sitting in WB, architectural regs, retire count
  logic        m_valid;
  logic [4:0]  m_dest;
  logic        m_we;
  logic [31:0] m_res, m_daddr, m_pc;
  logic [31:0] m_rf [32];
  int          m_cnt;
  always #5 clk = ~clk;
  wb_stage #(.RF_BYPASS(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mem2wb_bus_i(bus), .ctl_mem_over_i(mem_over),
    .ctl_wb_stall_i(stall), .ctl_wb_allowin_o(allowin), .ctl_wb_valid_o(valid),
    .ctl_wb_dest_o(dest), .ctl_wb_pc_o(pc), .rf_raddr1_i(raddr1), .rf_raddr2_i(raddr2),
    .rf_rdata1_o(rdata1), .rf_rdata2_o(rdata2), .debug_wb_pc_o(dpc),
    .debug_wb_rf_wen_o(wen), .debug_wb_rf_wnum_o(wnum), .debug_wb_rf_wdata_o(wdata),
    .debug_wb_daddr_o(daddr), .retire_cnt_o(cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_valid = 0; m_dest = 0; m_we = 0; m_res = 0; m_daddr = 0; m_pc = 0; m_cnt = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask
  function automatic logic m_commits();
    return m_valid && !stall && m_we && m_dest != 0;
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (m_commits() && a == m_dest) return m_res;
    return m_rf[a];
  endfunction
  task automatic check_all();
    logic retiring;
    retiring = m_valid && !stall;
    chk("allowin", 32'(allowin), 32'(!m_valid || retiring));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("ctl_dest", 32'(dest), (m_valid && m_we) ? 32'(m_dest) : 0);
    chk("ctl_pc", pc, m_pc);
    chk("rdata1", rdata1, m_read(raddr1));
    chk("rdata2", rdata2, m_read(raddr2));
    chk("dbg_pc", dpc, m_valid ? m_pc : 0);
    chk("dbg_wen", 32'(wen), m_commits() ? 32'hF : 0);
    chk("dbg_wnum", 32'(wnum), m_valid ? 32'(m_dest) : 0);
    chk("dbg_wdata", wdata, m_valid ? m_res : 0);
    chk("dbg_daddr", daddr, m_valid ? m_daddr : 0);
    chk("retire_cnt", 32'(cnt), 32'(m_cnt % (1 << CNT_W)));
  endtask
  // check settled outputs, take one clock edge, advance the model with the inputs seen at that edge
  task automatic cycle();
    logic retiring;
    #1 check_all();
    @(posedge clk);
    retiring = m_valid && !stall;
    if (!rst_n) model_reset();
    else begin
      if (m_commits()) m_rf[m_dest] = m_res;
      if (retiring) m_cnt++;
      if (!m_valid || retiring) begin
        m_valid = mem_over;
        if (mem_over) {m_dest, m_we, m_res, m_daddr, m_pc} = bus;
      end
    end
    #1;
  endtask
  task automatic send(input logic [4:0] d, input logic w, input logic [31:0] r, input logic [31:0] p);
    bus = {d, w, r, $urandom(), p};
    mem_over = 1'b1;
  endtask
  initial begin
    model_reset();
    #2 cycle();
    rst_n = 1'b1;
    cycle();
    // basic write to r5
    raddr1 = 5;
    send(5, 1, 32'hDEADBEEF, 32'h1C000000);
    cycle();
    mem_over = 0;
    #1 chk("t1_valid", 32'(valid), 1);
    chk("t1_wen", 32'(wen), 32'hF);
    chk("t1_wnum", 32'(wnum), 5);
    cycle();
    #1 chk("t1_rdata1", rdata1, 32'hDEADBEEF);
    chk("t1_cnt", 32'(cnt), 1);
    chk("t1_valid_drop", 32'(valid), 0);
    // write to r0 is dropped but still retires
    raddr1 = 0;
    send(0, 1, 32'h12345678, 32'h1C000004);
    cycle();
    mem_over = 0;
    #1 chk("r0_wen", 32'(wen), 0);
    chk("r0_read", rdata1, 0);
    cycle();
    chk("r0_cnt", 32'(cnt), 2);
    // same-cycle bypass on port 2
    raddr2 = 7;
    send(7, 1, 32'hA5A5A5A5, 32'h1C000008);
    cycle();
    mem_over = 0;
    #1 chk("bypass_rdata2", rdata2, 32'hA5A5A5A5);
    cycle();
    // back-to-back stream with a two-cycle stall on the second instruction
    raddr1 = 2; raddr2 = 3;
    for (int i = 1; i <= 4; i++) begin
      send(5'(i), 1, 32'(i), 32'h1C000100 + 32'(4 * i));
      if (i == 3) begin
        stall = 1;
        for (int s = 0; s < 2; s++) begin
          #1 chk("stall_allowin", 32'(allowin), 0);
          chk("stall_dest", 32'(dest), 2);
          chk("stall_wen", 32'(wen), 0);
          chk("stall_pc", pc, 32'h1C000108);
          cycle();
        end
        stall = 0;
      end
      cycle();
    end
    mem_over = 0;
    cycle();
    for (int i = 1; i <= 4; i++) begin
      raddr1 = 5'(i);
      #1 chk("stream_rf", rdata1, 32'(i));
    end
    chk("stream_cnt", 32'(cnt), 7);
    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      mem_over = $urandom_range(0, 9) < 7;
      stall = $urandom_range(0, 3) == 0;
      bus = {5'($urandom_range(0, 31)), 1'($urandom), $urandom(), $urandom(), $urandom()};
      raddr1 = ($urandom_range(0, 1) == 0) ? m_dest : 5'($urandom_range(0, 31));
      raddr2 = 5'($urandom_range(0, 31));
      cycle();
    end
    // counter wrap at 2^CNT_W-1 -> 0
    stall = 0;
    for (int n = 0; n < 64 && (m_cnt % 16) != 15; n++) begin
      send(5'($urandom_range(0, 31)), 1'($urandom), $urandom(), $urandom());
      cycle();
    end
    mem_over = 0;
    #1 chk("wrap_pre", 32'(cnt), 15);
    chk("wrap_valid", 32'(valid), 1);
    cycle();
    chk("wrap_zero", 32'(cnt), 0);
    // asynchronous reset while a write to r9 is stalled in WB
    send(9, 1, 32'h55, 32'h1C000200);
    cycle();
    mem_over = 0;
    stall = 1;
    cycle();
    #2 rst_n = 0;
    #1 model_reset();
    chk("async_valid", 32'(valid), 0);
    chk("async_allowin", 32'(allowin), 1);
    cycle();
    rst_n = 1;
    stall = 0;
    raddr1 = 9;
    cycle();
    chk("r9_after_reset", rdata1, 0);
    chk("allowin_after_reset", 32'(allowin), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
